// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MD_STALL,
        MD_RELEASE
    } hz_state_t;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-facing bundle: hazard inputs from IF/ID and ID/EX, stall/flush controls back.
interface hazard_stall_unit_if;
    import hazard_pkg::*;

    logic                 IDEX_MemRead;
    logic [REG_IDX_W-1:0] IDEX_Rt;
    logic                 IDEX_MulDiv;
    logic [REG_IDX_W-1:0] IFID_Rs;
    logic [REG_IDX_W-1:0] IFID_Rt;
    logic                 IFID_UsesRt;
    logic                 EX_BranchTaken;

    logic                 PCWrite;
    logic                 IFIDWrite;
    logic                 IFID_Flush;
    logic                 IDEX_Bubble;
    logic                 IDEX_Hold;
    logic                 Busy;

    // The pipeline side supplies hazard information and consumes the controls.
    modport master (
        output IDEX_MemRead, IDEX_Rt, IDEX_MulDiv, IFID_Rs, IFID_Rt, IFID_UsesRt, EX_BranchTaken,
        input  PCWrite, IFIDWrite, IFID_Flush, IDEX_Bubble, IDEX_Hold, Busy
    );

    modport slave (
        input  IDEX_MemRead, IDEX_Rt, IDEX_MulDiv, IFID_Rs, IFID_Rt, IFID_UsesRt, EX_BranchTaken,
        output PCWrite, IFIDWrite, IFID_Flush, IDEX_Bubble, IDEX_Hold, Busy
    );

endinterface

// File: rtl/hazard_stall_unit_stall_counter.sv
// Loadable down-counter with a zero flag, used to time the mul/div freeze.
module stall_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard controller: load-use stall, multi-cycle mul/div freeze, taken-branch flush.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    hazard_stall_unit_if.slave hz
);

    localparam int CNT_W = $clog2(MULDIV_LATENCY);

    hz_state_t        state;
    hz_state_t        state_next;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt;
    logic             lu;

    logic pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold, busy;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    stall_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (Clk),
        .rst      (Reset),
        .load     (cnt_load),
        .load_val (CNT_W'(MULDIV_LATENCY - 2)),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign lu = hz.IDEX_MemRead && (hz.IDEX_Rt != ZERO_REG) &&
                ((hz.IDEX_Rt == hz.IFID_Rs) ||
                 (hz.IFID_UsesRt && (hz.IDEX_Rt == hz.IFID_Rt)));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        busy        = 1'b0;

        unique case (state)
            IDLE, MD_RELEASE: begin
                state_next = IDLE;
                if (hz.EX_BranchTaken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (hz.IDEX_MulDiv && (state == IDLE)) begin
                    // In MD_RELEASE the mul/div flag belongs to the instruction leaving EX.
                    pc_hold    = 1'b1;
                    ifid_hold  = 1'b1;
                    idex_hold  = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = MD_STALL;
                end else if (lu) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end
            end
            MD_STALL: begin
                pc_hold   = 1'b1;
                ifid_hold = 1'b1;
                idex_hold = 1'b1;
                busy      = 1'b1;
                if (cnt_zero) begin
                    state_next = MD_RELEASE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Controls are forced quiet while reset is held, whatever the state.
        if (Reset) begin
            pc_hold     = 1'b0;
            ifid_hold   = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            idex_hold   = 1'b0;
            busy        = 1'b0;
        end
    end

    assign hz.PCWrite     = pc_hold;
    assign hz.IFIDWrite   = ifid_hold;
    assign hz.IFID_Flush  = ifid_flush;
    assign hz.IDEX_Bubble = idex_bubble;
    assign hz.IDEX_Hold   = idex_hold;
    assign hz.Busy        = busy;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: one instance at latency 4, one at latency 2.
module tb_hazard_stall_unit;

    typedef struct packed {
        logic       mem;
        logic [4:0] rt_ex;
        logic       md;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       br;
    } in_t;

    typedef struct {
        logic [5:0] outs;
        int         idx;
    } exp_t;

    // Expected output vectors: {PCWrite, IFIDWrite, IFID_Flush, IDEX_Bubble, IDEX_Hold, Busy}
    localparam logic [5:0] E_NONE = 6'b000000;
    localparam logic [5:0] E_LU   = 6'b110100;
    localparam logic [5:0] E_BR   = 6'b001100;
    localparam logic [5:0] E_MD   = 6'b110010;
    localparam logic [5:0] E_ST   = 6'b110011;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   step_idx;
    exp_t q4[$];
    exp_t q2[$];

    hazard_stall_unit_if if4 ();
    hazard_stall_unit_if if2 ();

    hazard_stall_unit #(.MULDIV_LATENCY(4)) dut4 (
        .Clk   (clk),
        .Reset (rst),
        .hz    (if4.slave)
    );

    hazard_stall_unit #(.MULDIV_LATENCY(2)) dut2 (
        .Clk   (clk),
        .Reset (rst),
        .hz    (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk(input logic mem, input logic [4:0] rt_ex, input logic md,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic uses, input logic br);
        in_t v;
        v.mem   = mem;
        v.rt_ex = rt_ex;
        v.md    = md;
        v.rs    = rs;
        v.rt    = rt;
        v.uses  = uses;
        v.br    = br;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [5:0] actual,
                         input logic [5:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s step=%0d got=%b expected=%b", name, idx, actual, expected);
        end
    endtask

    task automatic drive4(input in_t a);
        if4.IDEX_MemRead   = a.mem;
        if4.IDEX_Rt        = a.rt_ex;
        if4.IDEX_MulDiv    = a.md;
        if4.IFID_Rs        = a.rs;
        if4.IFID_Rt        = a.rt;
        if4.IFID_UsesRt    = a.uses;
        if4.EX_BranchTaken = a.br;
    endtask

    task automatic drive2(input in_t a);
        if2.IDEX_MemRead   = a.mem;
        if2.IDEX_Rt        = a.rt_ex;
        if2.IDEX_MulDiv    = a.md;
        if2.IFID_Rs        = a.rs;
        if2.IFID_Rt        = a.rt;
        if2.IFID_UsesRt    = a.uses;
        if2.EX_BranchTaken = a.br;
    endtask

    // One cycle of stimulus for both instances plus their expected responses.
    task automatic apply(input in_t a4, input in_t a2, input logic r,
                         input logic [5:0] e4, input logic [5:0] e2);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r;
        drive4(a4);
        drive2(a2);
        x.idx  = step_idx;
        x.outs = e4;
        q4.push_back(x);
        x.outs = e2;
        q2.push_back(x);
        step_idx++;
    endtask

    task automatic run4(input in_t a, input logic [5:0] e);
        apply(a, '0, 1'b0, e, E_NONE);
    endtask

    task automatic run2(input in_t a, input logic [5:0] e);
        apply('0, a, 1'b0, E_NONE, e);
    endtask

    // Monitor: every cycle both instances present their controls; compare against the queues.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q4.size() > 0) begin
                x = q4.pop_front();
                check("lat4_outputs", x.idx,
                      {if4.PCWrite, if4.IFIDWrite, if4.IFID_Flush,
                       if4.IDEX_Bubble, if4.IDEX_Hold, if4.Busy}, x.outs);
                if (if4.IDEX_Hold && if4.IDEX_Bubble)
                    check("lat4_hold_bubble_excl", x.idx, 6'b1, 6'b0);
            end
            if (q2.size() > 0) begin
                x = q2.pop_front();
                check("lat2_outputs", x.idx,
                      {if2.PCWrite, if2.IFIDWrite, if2.IFID_Flush,
                       if2.IDEX_Bubble, if2.IDEX_Hold, if2.Busy}, x.outs);
                if (if2.IDEX_Hold && if2.IDEX_Bubble)
                    check("lat2_hold_bubble_excl", x.idx, 6'b1, 6'b0);
            end
        end
    end

    initial begin
        in_t i0, lu8, md, lu3;
        checks   = 0;
        failures = 0;
        step_idx = 0;
        i0  = '0;
        lu8 = mk(1'b1, 5'd8, 1'b0, 5'd8, 5'd0, 1'b0, 1'b0);
        md  = mk(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        lu3 = mk(1'b1, 5'd3, 1'b0, 5'd3, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        drive4(i0);
        drive2(i0);

        // Reset: outputs quiet even with a mul/div presented.
        apply(i0, i0, 1'b1, E_NONE, E_NONE);
        apply(md, md, 1'b1, E_NONE, E_NONE);
        apply(i0, i0, 1'b0, E_NONE, E_NONE);

        // Load-use detection and its exclusions.
        run4(lu8, E_LU);
        run4(i0, E_NONE);
        run4(mk(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0), E_NONE);
        run4(mk(1'b1, 5'd0, 1'b0, 5'd8, 5'd0, 1'b0, 1'b0), E_NONE);
        run4(mk(1'b1, 5'd8, 1'b0, 5'd1, 5'd8, 1'b0, 1'b0), E_NONE);
        run4(mk(1'b1, 5'd8, 1'b0, 5'd1, 5'd8, 1'b1, 1'b0), E_LU);
        run4(mk(1'b0, 5'd8, 1'b0, 5'd8, 5'd8, 1'b1, 1'b0), E_NONE);
        run4(lu8, E_LU);
        run4(lu8, E_LU);

        // Branch wins over a simultaneous load-use.
        run4(mk(1'b1, 5'd8, 1'b0, 5'd8, 5'd0, 1'b0, 1'b1), E_BR);
        run4(i0, E_NONE);

        // Mul/div held: 4 stall cycles, branch/lu ignored in MD_STALL, no re-trigger on release.
        run4(md, E_MD);
        run4(md, E_ST);
        run4(mk(1'b1, 5'd8, 1'b1, 5'd8, 5'd0, 1'b0, 1'b1), E_ST);
        run4(md, E_ST);
        run4(md, E_NONE);
        run4(i0, E_NONE);

        // Release cycle with a load-use hazard.
        run4(md, E_MD);
        run4(md, E_ST);
        run4(md, E_ST);
        run4(md, E_ST);
        run4(lu3, E_LU);
        run4(i0, E_NONE);

        // Release cycle with a taken branch, then a new mul/div right after release.
        run4(md, E_MD);
        run4(md, E_ST);
        run4(md, E_ST);
        run4(md, E_ST);
        run4(mk(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b1), E_BR);
        run4(md, E_MD);
        run4(md, E_ST);
        run4(md, E_ST);

        // Reset in the middle of MD_STALL, then idle inputs stay quiet.
        apply(i0, i0, 1'b1, E_NONE, E_NONE);
        run4(i0, E_NONE);
        run4(i0, E_NONE);

        // Reset aborts a stall: a mul/div straight after reset starts fresh from IDLE.
        run4(md, E_MD);
        run4(md, E_ST);
        run4(md, E_ST);
        apply(md, i0, 1'b1, E_NONE, E_NONE);
        run4(md, E_MD);
        run4(md, E_ST);
        run4(md, E_ST);
        run4(md, E_ST);
        run4(i0, E_NONE);
        run4(i0, E_NONE);

        // Latency 2: exactly 2 stall cycles then a release cycle.
        run2(md, E_MD);
        run2(md, E_ST);
        run2(md, E_NONE);
        run2(i0, E_NONE);
        run2(md, E_MD);
        run2(md, E_ST);
        run2(lu3, E_LU);
        run2(md, E_MD);
        run2(i0, E_ST);
        run2(i0, E_NONE);
        run2(i0, E_NONE);

        @(negedge clk);
        #1;
        check("scoreboard_drain_lat4", step_idx, 6'(q4.size()), 6'd0);
        check("scoreboard_drain_lat2", step_idx, 6'(q2.size()), 6'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller that drives the hold input of the program counter, the IF/ID hold and flush, and the ID/EX bubble and hold. It detects load-use hazards, freezes the front end and EX for multi-cycle multiply/divide, and flushes wrong-path instructions on a taken branch. It sits beside the IF/ID and ID/EX registers and drives the PC's `PCWrite` input, where `PCWrite=1` means the PC holds its value.

## Interface
- `MULDIV_LATENCY`, default 4: total stall cycles for a mul/div in EX; legal range ≥ 2.

- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `IDEX_MemRead` in 1: the instruction in EX is a load.
- `IDEX_Rt` in 5: destination register of the load in EX.
- `IDEX_MulDiv` in 1: the instruction in EX is a multi-cycle mul/div.
- `IFID_Rs` in 5: first source register of the instruction in ID.
- `IFID_Rt` in 5: second source register of the instruction in ID.
- `IFID_UsesRt` in 1: `IFID_Rt` is a true source operand.
- `EX_BranchTaken` in 1: a branch or jump in EX is resolved as taken this cycle.
- `PCWrite` out 1: 1 = PC holds.
- `IFIDWrite` out 1: 1 = IF/ID holds.
- `IFID_Flush` out 1: clears IF/ID to a NOP at the next edge.
- `IDEX_Bubble` out 1: zeroes the control fields entering ID/EX.
- `IDEX_Hold` out 1: ID/EX holds, so the instruction stays in EX.
- `Busy` out 1: high in `MD_STALL`.

## Operation
- States: `IDLE`, `MD_STALL`, `MD_RELEASE`. There is one down-counter `cnt` of width `$clog2(MULDIV_LATENCY)`.
- Outputs are combinational from the current state and the inputs. State and `cnt` are registered.
- Load-use condition (`lu`):
  - `IDEX_MemRead && IDEX_Rt!=0`, and
  - either `IDEX_Rt==IFID_Rs`, or `IFID_UsesRt && IDEX_Rt==IFID_Rt`.
- `IDLE` and `MD_RELEASE` evaluate events in this priority order:
  1. `EX_BranchTaken`: `IFID_Flush=1`, `IDEX_Bubble=1`, `PCWrite=0` (the PC loads the target). The load-use stall is suppressed.
  2. `IDEX_MulDiv` (in `IDLE` only): `PCWrite=IFIDWrite=IDEX_Hold=1`. Load `cnt<=MULDIV_LATENCY-2` and go to `MD_STALL`.
  3. `lu`: `PCWrite=IFIDWrite=IDEX_Bubble=1` for one cycle, then re-evaluate. No extra state is needed, because the load has left EX by the next cycle.
  4. Otherwise all outputs are 0.
- `MD_STALL`:
  - `PCWrite=IFIDWrite=IDEX_Hold=Busy=1`. `lu` and `EX_BranchTaken` are ignored, since EX holds the mul/div.
  - If `cnt==0`, go to `MD_RELEASE`; otherwise `cnt<=cnt-1`.
- `MD_RELEASE` lasts exactly one cycle:
  - `IDEX_MulDiv` is ignored (it is the same instruction leaving EX). Rules 1, 3 and 4 apply.
  - Next state is `IDLE`.
- `IDEX_Hold` and `IDEX_Bubble` are never both 1.

## Timing
- Load-use: exactly 1 stall cycle, asserted in the same cycle `lu` is true. Back-to-back load-use hazards each cost 1 cycle.
- Mul/div: stall signals are high for exactly `MULDIV_LATENCY` consecutive cycles (the detection cycle plus `MULDIV_LATENCY-1` cycles in `MD_STALL`), followed by one `MD_RELEASE` cycle with no mul/div stall.
- Branch flush takes effect at the next edge. Zero latency from `EX_BranchTaken` to the outputs.
- Reset:
  - While `Reset=1`, all outputs are 0. At the edge, state becomes `IDLE` and `cnt` becomes 0.
  - Reset in the middle of `MD_STALL` aborts the stall immediately. The next cycle is `IDLE` with no release cycle.
- A mul/div that follows `MD_RELEASE` in the very next cycle is a new instruction and triggers a new stall from `IDLE`.

## Structure
- Shared package `hazard_pkg` holds:
  - state enum `hz_state_t` {`IDLE`, `MD_STALL`, `MD_RELEASE`};
  - `REG_IDX_W=5`;
  - `ZERO_REG=5'd0`.
- One optional sub-module, `stall_counter`: a loadable down-counter with a `zero` flag. Everything else is flat.

## Test plan
- Load-use: `IDEX_MemRead=1`, `IDEX_Rt=8`, `IFID_Rs=8` → `PCWrite=IFIDWrite=IDEX_Bubble=1` for exactly 1 cycle. The same stimulus with `IDEX_Rt=0`, or with `IFID_Rt=8` and `IFID_UsesRt=0`, gives no stall.
- Mul/div: `IDEX_MulDiv=1` held, `MULDIV_LATENCY=4` → `PCWrite=IDEX_Hold=1` for 4 cycles and `Busy=1` for 3 cycles, then 1 cycle with all outputs 0, with no re-trigger.
- Branch over load-use: `EX_BranchTaken=1` together with a true `lu` → `IFID_Flush=1`, `IDEX_Bubble=1`, `PCWrite=0`.
- Reset after the second `MD_STALL` cycle → all outputs 0 in the reset cycle. After reset, with `IDEX_MulDiv=0`, outputs stay 0.
- `MD_RELEASE` with `lu` true (`IDEX_MemRead=1`, `IDEX_Rt=3`, `IFID_Rs=3`) → 1-cycle load-use stall, then return to `IDLE`.
- `MULDIV_LATENCY=2` → exactly 2 stall cycles followed by a release cycle.
